// File: rtl/alu_divider_pkg.sv
// Shared NPC package: divider op encodings and FSM state encoding.
// The ALU decoder uses the same op enum when it issues divide operations.
package alu_divider_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } div_state_e;

   // True for the two's-complement variants (DIV, REM)
   function automatic logic op_is_signed(input div_op_e o);
      return (o == OP_DIV) || (o == OP_REM);
   endfunction

   // True when the caller wants the remainder rather than the quotient
   function automatic logic op_is_rem(input div_op_e o);
      return (o == OP_REM) || (o == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_divider_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not go negative and shift the resulting quotient bit in.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic [WIDTH-1:0] next_quo
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;
   logic           qbit_s;

   // Shift / compare / subtract for a single quotient bit
   always_comb begin
      shifted_s = {rem, quo[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, divisor};
      qbit_s    = ~diff_s[WIDTH];
      next_rem  = shifted_s[WIDTH-1:0];
      if (qbit_s) begin
         next_rem = diff_s[WIDTH-1:0];
      end else begin
         next_rem = shifted_s[WIDTH-1:0];
      end
      next_quo = {quo[WIDTH-2:0], qbit_s};
   end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle integer divider for the ALU: DIV/DIVU/REM/REMU with a
// valid/ready handshake on both sides. Divide-by-zero and signed overflow
// complete on the accept edge; all other ops take WIDTH CALC cycles.
module alu_divider
   import alu_divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES      = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       state_r, state_nxt_s;
   div_op_e          op_r, op_in_s;
   logic             neg_q_r, neg_r_r;
   logic [WIDTH-1:0] divisor_r, rem_r, quo_r, result_r;
   logic [CW-1:0]    cnt_r;

   logic             accept_s, in_signed_s, div0_s, ovf_s, special_s, last_step_s;
   logic             src1_neg_s, src2_neg_s;
   logic [WIDTH-1:0] mag1_s, mag2_s, special_res_s;
   logic [WIDTH-1:0] step_rem_s, step_quo_s, fix_q_s, fix_r_s, final_res_s;

   assign op_in_s = div_op_e'(op);

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem      (rem_r),
      .quo      (quo_r),
      .divisor  (divisor_r),
      .next_rem (step_rem_s),
      .next_quo (step_quo_s)
   );

   // Decode the offered operation: magnitudes and the two early-out cases
   always_comb begin
      accept_s    = in_valid & (state_r == ST_IDLE) & ~flush;
      in_signed_s = op_is_signed(op_in_s);
      src1_neg_s  = in_signed_s & src1[WIDTH-1];
      src2_neg_s  = in_signed_s & src2[WIDTH-1];
      mag1_s      = src1_neg_s ? (ZERO - src1) : src1;
      mag2_s      = src2_neg_s ? (ZERO - src2) : src2;
      div0_s      = (src2 == ZERO);
      ovf_s       = in_signed_s & (src1 == MOST_NEG) & (src2 == ONES);
      special_s   = div0_s | ovf_s;
      special_res_s = ZERO;
      if (div0_s) begin
         special_res_s = op_is_rem(op_in_s) ? src1 : ONES;
      end else begin
         special_res_s = op_is_rem(op_in_s) ? ZERO : src1;
      end
   end

   // Sign fix-up of the final step's quotient/remainder on entry to DONE
   always_comb begin
      last_step_s = (cnt_r == LAST_STEP);
      fix_q_s     = neg_q_r ? (ZERO - step_quo_s) : step_quo_s;
      fix_r_s     = neg_r_r ? (ZERO - step_rem_s) : step_rem_s;
      final_res_s = op_is_rem(op_r) ? fix_r_s : fix_q_s;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state; flush overrides accept and the output handshake
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = special_s ? ST_DONE : ST_CALC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_nxt_s = ST_IDLE;
            end else if (last_step_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_CALC;
            end
         end
         ST_DONE: begin
            if (flush || out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath: latch operands on accept, iterate in CALC, hold result in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r      <= OP_DIV;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         divisor_r <= ZERO;
         rem_r     <= ZERO;
         quo_r     <= ZERO;
         cnt_r     <= {CW{1'b0}};
         result_r  <= ZERO;
      end else if (flush) begin
         cnt_r    <= {CW{1'b0}};
         result_r <= ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r      <= op_in_s;
                  neg_q_r   <= src1_neg_s ^ src2_neg_s;
                  neg_r_r   <= src1_neg_s;
                  divisor_r <= mag2_s;
                  quo_r     <= mag1_s;
                  rem_r     <= ZERO;
                  cnt_r     <= {CW{1'b0}};
                  result_r  <= special_s ? special_res_s : ZERO;
               end
            end
            ST_CALC: begin
               rem_r <= step_rem_s;
               quo_r <= step_quo_s;
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (last_step_s) begin
                  result_r <= final_res_s;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  result_r <= ZERO;
               end
            end
            default: begin
               cnt_r    <= {CW{1'b0}};
               result_r <= ZERO;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == ST_IDLE);
   assign out_valid = (state_r == ST_DONE);
   assign result    = result_r;

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: flush  input  1  synchronous abort of any in-flight operation.
REQ-005 Port: in_valid  input  1  upstream offers an operation.
REQ-006 Port: in_ready  output  1  block can accept an operation.
REQ-007 Port: op  input  2  operation code: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 Port: src1  input  WIDTH  dividend.
REQ-009 Port: src2  input  WIDTH  divisor.
REQ-010 Port: out_valid  output  1  result available to the ALU result selector.
REQ-011 Port: out_ready  input  1  downstream consumes result.
REQ-012 Port: result  output  WIDTH  quotient or remainder per op.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-015 An operation SHALL be accepted on a rising edge where in_valid & in_ready & ~flush; op, sign flags and operand magnitudes are latched on that edge.
REQ-016 Normal operations SHALL use radix-2 restoring division on unsigned magnitudes, one quotient bit per CALC cycle, with a step counter counting 0..WIDTH-1.
REQ-017 Latency: out_valid SHALL first be high in the cycle following the WIDTH-th rising edge after the accept edge (32 edges for WIDTH=32).
REQ-018 Signed ops SHALL truncate the quotient toward zero; the remainder sign SHALL equal the dividend sign; the final sign fix-up SHALL be applied when entering DONE.
REQ-019 Divide by zero (src2 == 0): IDLE->DONE on the accept edge; quotient SHALL be all ones, remainder SHALL be src1 (signed and unsigned).
REQ-020 Signed overflow (DIV/REM, src1 == most-negative, src2 == all ones): IDLE->DONE on the accept edge; quotient SHALL be src1, remainder SHALL be 0.
REQ-021 In DONE, result SHALL hold stable while out_valid & ~out_ready; on out_valid & out_ready the FSM SHALL return to IDLE on that edge.
REQ-022 No accept SHALL occur in DONE or CALC (no back-to-back overlap); the next accept is possible one cycle after the output handshake.
REQ-023 flush SHALL force IDLE on the next edge from any state, discard in-flight or pending results, and take priority over accept and output handshake.
REQ-024 result SHALL be 0 whenever out_valid is low.

Reset
REQ-025 On rst_n low, the FSM SHALL enter IDLE asynchronously; the counter, latched operands, partial remainder and quotient SHALL clear to 0.
REQ-026 Reset values SHALL be in_ready = 1, out_valid = 0, result = 0; reset asserted mid-CALC SHALL discard the operation with no later out_valid.

Structure
REQ-027 Op encodings (DIV/DIVU/REM/REMU) and the FSM state encoding SHALL live in the shared NPC package, also used by the ALU decoder.
REQ-028 One combinational sub-module, div_step, SHALL perform a single shift/compare/subtract step (partial remainder, quotient in; updated pair out).
REQ-029 The output of alu_divider SHALL connect to one data input of the ALU result selector, with no extra register stage.

Verification
REQ-030 DIVU 100/7 -> result 14 exactly 32 edges after accept; REMU 100/7 -> 2.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, out_valid 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 out_ready held low 10 cycles in DONE -> result stable, in_ready stays 0; out_ready high -> IDLE next edge.
REQ-034 flush at CALC step 10 with in_valid high -> IDLE next edge, no accept, no out_valid; the next op completes correctly.
REQ-035 rst_n pulsed low mid-CALC -> immediate IDLE, out_valid 0, in_ready 1; the subsequent DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
